// File: rtl/demux1_4_tdm.sv
// -----------------------------------------------------------------------------
// demux1_4_tdm
// Registered 1-to-4 time-division demultiplexer. This is the receive-side
// partner of the 4:1 TDM multiplexer. One W-bit lane carries channels A, B, C
// and D in round-robin order. The sof marker flags the channel-A sample. Each
// sample is routed to its own output register, and per-channel and per-frame
// completion are signalled with one-cycle strobes.
//
// Optional build macro: DEMUX1_4_SHADOW_EN
//   When defined, samples collect in shadow registers, and A..D update
//   atomically in the frame_done cycle with ch_valid = 4'b1111.
//   A truncated frame never reaches A..D.
//   When undefined, each channel output updates as soon as its own sample
//   arrives.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   nEN        in   active-low enable; 1 freezes state, strobes forced 0
//   din        in   W-bit multiplexed sample
//   din_valid  in   din carries a sample this cycle
//   sof        in   start of frame (channel-A sample), qualified by din_valid
//   A,B,C,D    out  channel 0..3 output registers
//   ch_valid   out  per-channel write strobe (bit0 = A)
//   S          out  channel index for the next accepted sample
//   locked     out  high in LOCKED
//   frame_done out  pulse when the channel-D sample of a frame is written
//   sync_err   out  pulse on an unexpected sof, or on a missing sof
//
// state  | meaning
// HUNT   | waiting for a sof beat; non-sof beats are dropped
// LOCKED | aligned to frames; S tracks the expected channel
// -----------------------------------------------------------------------------
module demux1_4_tdm #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         nEN,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   input  logic         sof,
   output logic [W-1:0] A,
   output logic [W-1:0] B,
   output logic [W-1:0] C,
   output logic [W-1:0] D,
   output logic [3:0]   ch_valid,
   output logic [1:0]   S,
   output logic         locked,
   output logic         frame_done,
   output logic         sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          s_q, s_d;
   logic [3:0][W-1:0]   out_q, out_d;
   logic [3:0]          cv_q, cv_d;
   logic                fd_q, fd_d;
   logic                se_q, se_d;

   logic                accept;
   logic                wr;
   logic [1:0]          wr_idx;

`ifdef DEMUX1_4_SHADOW_EN
   // Only A..C need shadowing; the D sample goes straight to the output
   // in the commit cycle.
   logic [2:0][W-1:0]   shd_q, shd_d;
`endif

   assign accept = ~nEN & din_valid;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      out_d   = out_q;
      cv_d    = 4'b0000;
      fd_d    = 1'b0;
      se_d    = 1'b0;
      wr      = 1'b0;
      wr_idx  = 2'd0;
`ifdef DEMUX1_4_SHADOW_EN
      shd_d   = shd_q;
`endif

      if (accept) begin
         case (state_q)
            HUNT: begin
               if (sof) begin
                  wr      = 1'b1;
                  wr_idx  = 2'd0;
                  s_d     = 2'd1;
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (sof) begin
                  // A sof beat restarts the frame at channel A. If the
                  // current frame was not complete, it is a short frame.
                  wr     = 1'b1;
                  wr_idx = 2'd0;
                  s_d    = 2'd1;
                  se_d   = (s_q != 2'd0);
               end else if (s_q == 2'd0) begin
                  // The marker was expected but missing, so realignment
                  // is lost.
                  se_d    = 1'b1;
                  s_d     = 2'd0;
                  state_d = HUNT;
               end else begin
                  wr     = 1'b1;
                  wr_idx = s_q;
                  s_d    = s_q + 2'd1;
                  fd_d   = (s_q == 2'd3);
               end
            end
            default: state_d = HUNT;
         endcase
      end

`ifdef DEMUX1_4_SHADOW_EN
      if (wr) begin
         case (wr_idx)
            2'd0:    shd_d[0] = din;
            2'd1:    shd_d[1] = din;
            2'd2:    shd_d[2] = din;
            default: ;
         endcase
      end
      if (fd_d) begin
         out_d = {din, shd_q[2], shd_q[1], shd_q[0]};
         cv_d  = 4'b1111;
      end
`else
      if (wr) begin
         out_d[wr_idx] = din;
         cv_d[wr_idx]  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         s_q     <= 2'd0;
         out_q   <= '0;
         cv_q    <= 4'b0000;
         fd_q    <= 1'b0;
         se_q    <= 1'b0;
`ifdef DEMUX1_4_SHADOW_EN
         shd_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         out_q   <= out_d;
         cv_q    <= cv_d;
         fd_q    <= fd_d;
         se_q    <= se_d;
`ifdef DEMUX1_4_SHADOW_EN
         shd_q   <= shd_d;
`endif
      end
   end

   assign A          = out_q[0];
   assign B          = out_q[1];
   assign C          = out_q[2];
   assign D          = out_q[3];
   assign ch_valid   = cv_q;
   assign S          = s_q;
   assign locked     = (state_q == LOCKED);
   assign frame_done = fd_q;
   assign sync_err   = se_q;

endmodule

// File: tb/tb_demux1_4_tdm.sv
module tb_demux1_4_tdm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       nEN;
   logic [1:0] din;
   logic       din_valid;
   logic       sof;
   logic [1:0] A, B, C, D;
   logic [3:0] ch_valid;
   logic [1:0] S;
   logic       locked, frame_done, sync_err;

   typedef struct {
      logic [1:0] a, b, c, d;
      logic [3:0] cv;
      logic [1:0] s;
      logic       l, fd, se;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   bit   done   = 1'b0;

   demux1_4_tdm #(.W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .nEN        (nEN),
      .din        (din),
      .din_valid  (din_valid),
      .sof        (sof),
      .A          (A),
      .B          (B),
      .C          (C),
      .D          (D),
      .ch_valid   (ch_valid),
      .S          (S),
      .locked     (locked),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus and queue the registered response expected
   // after the edge.
   task automatic step(input logic nen, input logic dv, input logic sf, input logic [1:0] dn,
                       input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ec,
                       input logic [1:0] ed, input logic [3:0] ecv, input logic [1:0] es,
                       input logic el, input logic efd, input logic ese);
      exp_t e;
      @(negedge clk);
      rst_n = 1'b1; nEN = nen; din_valid = dv; sof = sf; din = dn;
      @(posedge clk);
      e.a = ea; e.b = eb; e.c = ec; e.d = ed; e.cv = ecv;
      e.s = es; e.l = el; e.fd = efd; e.se = ese;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clk);
      rst_n = 1'b0; nEN = 1'b0; din_valid = 1'b1; sof = 1'b1; din = 2'd3;
      @(posedge clk);
      e.a = 0; e.b = 0; e.c = 0; e.d = 0; e.cv = 0; e.s = 0; e.l = 0; e.fd = 0; e.se = 0;
      exp_q.push_back(e);
   endtask

   // The monitor compares each queued expectation with the DUT outputs at
   // the falling edge after the corresponding rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (A !== e.a || B !== e.b || C !== e.c || D !== e.d || ch_valid !== e.cv ||
                S !== e.s || locked !== e.l || frame_done !== e.fd || sync_err !== e.se) begin
               n_miss++;
               $display("FAIL vec%0d got A=%0d B=%0d C=%0d D=%0d cv=%b S=%0d lk=%b fd=%b se=%b want A=%0d B=%0d C=%0d D=%0d cv=%b S=%0d lk=%b fd=%b se=%b",
                        n_vec, A, B, C, D, ch_valid, S, locked, frame_done, sync_err,
                        e.a, e.b, e.c, e.d, e.cv, e.s, e.l, e.fd, e.se);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; nEN = 1'b0; din = 2'd0; din_valid = 1'b0; sof = 1'b0;
`ifndef DEMUX1_4_SHADOW_EN
      do_reset();
      step(0,1,1,2'd1, 1,0,0,0, 4'b0001, 1, 1,0,0);
      step(0,1,0,2'd2, 1,2,0,0, 4'b0010, 2, 1,0,0);
      step(0,1,0,2'd3, 1,2,3,0, 4'b0100, 3, 1,0,0);
      step(0,1,0,2'd0, 1,2,3,0, 4'b1000, 0, 1,1,0);
      step(0,1,0,2'd1, 1,2,3,0, 4'b0000, 0, 0,0,1);   // missing sof
      step(1,1,1,2'd2, 1,2,3,0, 4'b0000, 0, 0,0,0);   // disabled, sof ignored
      do_reset();
      step(0,1,0,2'd3, 0,0,0,0, 4'b0000, 0, 0,0,0);   // hunt drop
      step(0,1,0,2'd3, 0,0,0,0, 4'b0000, 0, 0,0,0);
      step(0,1,1,2'd2, 2,0,0,0, 4'b0001, 1, 1,0,0);
      step(0,1,0,2'd1, 2,1,0,0, 4'b0010, 2, 1,0,0);
      for (int i = 0; i < 3; i++) step(0,0,0,2'd1, 2,1,0,0, 4'b0000, 2, 1,0,0);
      for (int i = 0; i < 2; i++) step(1,1,0,2'd1, 2,1,0,0, 4'b0000, 2, 1,0,0);
      step(0,1,0,2'd1, 2,1,1,0, 4'b0100, 3, 1,0,0);
      step(0,1,0,2'd3, 2,1,1,3, 4'b1000, 0, 1,1,0);
      step(0,1,1,2'd0, 0,1,1,3, 4'b0001, 1, 1,0,0);   // sof at S=0, no error
      step(0,1,0,2'd2, 0,2,1,3, 4'b0010, 2, 1,0,0);
      step(0,1,1,2'd3, 3,2,1,3, 4'b0001, 1, 1,0,1);   // short frame
      step(0,0,1,2'd2, 3,2,1,3, 4'b0000, 1, 1,0,0);   // sof without valid
      step(0,1,0,2'd1, 3,1,1,3, 4'b0010, 2, 1,0,0);
      step(0,1,0,2'd2, 3,1,2,3, 4'b0100, 3, 1,0,0);
      step(0,1,0,2'd0, 3,1,2,0, 4'b1000, 0, 1,1,0);
      step(0,1,1,2'd1, 1,1,2,0, 4'b0001, 1, 1,0,0);
      do_reset();                                      // mid-frame reset
      step(0,1,0,2'd2, 0,0,0,0, 4'b0000, 0, 0,0,0);
`else
      do_reset();
      step(0,1,1,2'd1, 0,0,0,0, 4'b0000, 1, 1,0,0);
      step(0,1,0,2'd2, 0,0,0,0, 4'b0000, 2, 1,0,0);
      step(0,1,0,2'd3, 0,0,0,0, 4'b0000, 3, 1,0,0);
      step(0,1,0,2'd0, 1,2,3,0, 4'b1111, 0, 1,1,0);
      step(0,1,0,2'd1, 1,2,3,0, 4'b0000, 0, 0,0,1);
      step(1,1,1,2'd2, 1,2,3,0, 4'b0000, 0, 0,0,0);
      do_reset();
      step(0,1,0,2'd3, 0,0,0,0, 4'b0000, 0, 0,0,0);
      step(0,1,0,2'd3, 0,0,0,0, 4'b0000, 0, 0,0,0);
      step(0,1,1,2'd2, 0,0,0,0, 4'b0000, 1, 1,0,0);
      step(0,1,0,2'd1, 0,0,0,0, 4'b0000, 2, 1,0,0);
      for (int i = 0; i < 3; i++) step(0,0,0,2'd1, 0,0,0,0, 4'b0000, 2, 1,0,0);
      for (int i = 0; i < 2; i++) step(1,1,0,2'd1, 0,0,0,0, 4'b0000, 2, 1,0,0);
      step(0,1,0,2'd1, 0,0,0,0, 4'b0000, 3, 1,0,0);
      step(0,1,0,2'd3, 2,1,1,3, 4'b1111, 0, 1,1,0);
      step(0,1,1,2'd0, 2,1,1,3, 4'b0000, 1, 1,0,0);
      step(0,1,0,2'd2, 2,1,1,3, 4'b0000, 2, 1,0,0);
      step(0,1,1,2'd3, 2,1,1,3, 4'b0000, 1, 1,0,1);   // truncated frame discarded
      step(0,0,1,2'd2, 2,1,1,3, 4'b0000, 1, 1,0,0);
      step(0,1,0,2'd1, 2,1,1,3, 4'b0000, 2, 1,0,0);
      step(0,1,0,2'd2, 2,1,1,3, 4'b0000, 3, 1,0,0);
      step(0,1,0,2'd0, 3,1,2,0, 4'b1111, 0, 1,1,0);
      step(0,1,1,2'd1, 3,1,2,0, 4'b0000, 1, 1,0,0);
      do_reset();
      step(0,1,0,2'd2, 0,0,0,0, 4'b0000, 0, 0,0,0);
`endif
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/demux1_4_tdm.md
Name: demux1_4_tdm

Overview:
- Registered 1-to-4 time-division demultiplexer. It is the receive-side counterpart of the 4:1 multiplexer.
- Takes one W-bit sample lane carrying channels A, B, C, D in round-robin order, with a start-of-frame marker on channel A.
- Routes each sample to its own channel output register and signals per-channel and per-frame completion.
- Sits between a serialised link and the parallel consumers of the four channels.

Parameters:
- W, 2, sample/channel data width in bits (W >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nEN  in  1  active-low block enable; 1 freezes all state and outputs.
- din  in  W  incoming multiplexed sample.
- din_valid  in  1  din carries a sample this cycle.
- sof  in  1  start of frame; meaningful only with din_valid=1; marks the channel-A sample.
- A  out  W  channel 0 output register.
- B  out  W  channel 1 output register.
- C  out  W  channel 2 output register.
- D  out  W  channel 3 output register.
- ch_valid  out  4  one-cycle strobe; bit k=1 when channel k was written (bit0=A).
- S  out  2  index of the channel the next accepted sample will go to.
- locked  out  1  1 in LOCKED state.
- frame_done  out  1  one-cycle pulse when the channel-D sample of a frame is written.
- sync_err  out  1  one-cycle pulse on unexpected sof.

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT, S=0, A=B=C=D=0, ch_valid=0, locked=0, frame_done=0, sync_err=0.
- Reset asserted mid-frame discards the partial frame; after release the block re-hunts.
- All outputs are registered. A sample accepted at edge n appears on its output, with its strobe, after edge n (latency 1 cycle).
- "Accepted" means nEN=0 and din_valid=1 at a rising edge.
- Strobes ch_valid, frame_done and sync_err default to 0 every cycle when not asserted.
- nEN=1: inputs ignored; state, S, A..D and locked hold; strobes forced 0.
- State HUNT:
  - Accepted beat with sof=0: dropped, no strobe.
  - Accepted beat with sof=1: din written to A, ch_valid=0001, S=1, go to LOCKED.
- State LOCKED, accepted beat with sof=0:
  - din written to channel S, ch_valid bit S set, S=S+1 mod 4.
  - If S was 3: frame_done=1 and S wraps to 0.
- State LOCKED, accepted beat with sof=1 and S=0: normal channel-A write, no error.
- State LOCKED, accepted beat with sof=1 and S!=0 (short frame):
  - sync_err=1, din written to A, ch_valid=0001, S=1.
  - Remain LOCKED; no frame_done for the truncated frame.
- State LOCKED, accepted beat with sof=0 and S=0 (missing marker): sync_err=1, beat dropped, go to HUNT, S=0.
- din_valid=0 cycles inside a frame are gaps. They are allowed, S holds, and there is no timeout.
- sof sampled with din_valid=0 is ignored.
- locked = (state==LOCKED).

Optional Feature:
- Macro: DEMUX1_4_SHADOW_EN.
- Defined:
  - Samples are written into internal shadow registers.
  - A..D update together, atomically, in the same cycle frame_done pulses, i.e. one cycle after the channel-D beat is accepted.
  - ch_valid pulses 1111 in that cycle only.
  - A truncated frame (sync_err) never reaches A..D; shadow registers are reset with the block.
- Not defined: per-channel update as described in Behaviour; no shadow registers are synthesised.

Test Plan:
- Reset then lock:
  - Stimulus: rst_n=0 pulse, nEN=0; beats din=1,2,3,0 with sof on the first beat, din_valid=1 continuously.
  - Required: after 4th edge A=1, B=2, C=3, D=0; ch_valid sequence 0001, 0010, 0100, 1000; frame_done=1 on the last; S=0; locked=1.
- Hunt drop:
  - Stimulus: from reset, beats din=3,3 with sof=0, then din=2 with sof=1.
  - Required: first two dropped (A=0, no strobe, locked=0); then A=2, locked=1, S=1.
- Gaps and enable:
  - Stimulus: while locked at S=2, din_valid=0 for 3 cycles, then nEN=1 with din_valid=1 din=1 for 2 cycles, then nEN=0 with din=1.
  - Required: S stays 2 throughout; only the final beat writes C=1, ch_valid=0100.
- Short frame:
  - Stimulus: locked at S=2, beat din=3 with sof=1.
  - Required: sync_err=1, A=3, S=1, locked=1, frame_done=0.
- Missing sof:
  - Stimulus: after frame_done (S=0), beat din=1 with sof=0.
  - Required: sync_err=1, locked=0, A unchanged, S=0.
- Shadow (DEMUX1_4_SHADOW_EN):
  - Stimulus: repeat the reset-then-lock test.
  - Required: A..D remain 0 during beats 1–3; all become 1, 2, 3, 0 in the frame_done cycle, with ch_valid=1111.
